// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel gradient stage.
// Contents: pixel/gradient/magnitude widths, the four-row column
// struct, and helpers for the Sobel weighted sums and differences.
package sobel_pkg;

    localparam int PIXW      = 16;        // pixel width
    localparam int GRADW     = 19;        // signed Gx/Gy width
    localparam int MAGW      = 20;        // |Gx|+|Gy| width
    localparam int SUMW      = PIXW + 2;  // weighted sum of three pixels (max 4*65535)
    localparam int DIFW      = PIXW + 1;  // signed difference of two pixels
    localparam int MID_SHIFT = 1;         // Sobel centre tap weight 2 = shift by one

    // One column of the four stacked rows, row A on top.
    typedef struct packed {
        logic [PIXW-1:0] pixA;
        logic [PIXW-1:0] pixB;
        logic [PIXW-1:0] pixC;
        logic [PIXW-1:0] pixD;
    } colWin_t;

    // 1-2-1 weighted sum of three unsigned pixels.
    function automatic logic [SUMW-1:0] weightedSum(input logic [PIXW-1:0] p0,
                                                    input logic [PIXW-1:0] p1,
                                                    input logic [PIXW-1:0] p2);
        return {2'b00, p0} + ({2'b00, p1} << MID_SHIFT) + {2'b00, p2};
    endfunction

    // 1-2-1 weighted sum of three signed differences, sign-extended to GRADW.
    function automatic logic signed [GRADW-1:0] weightedDiff(input logic signed [DIFW-1:0] d0,
                                                             input logic signed [DIFW-1:0] d1,
                                                             input logic signed [DIFW-1:0] d2);
        return GRADW'(d0) + (GRADW'(d1) <<< MID_SHIFT) + GRADW'(d2);
    endfunction

    // Absolute value; the full negative range of a 19-bit gradient is never
    // reached (|min| = 262140), so the result always fits unsigned GRADW bits.
    function automatic logic [GRADW-1:0] absVal(input logic signed [GRADW-1:0] v);
        if (v[GRADW-1]) begin
            return GRADW'(-v);
        end else begin
            return GRADW'(v);
        end
    endfunction

endpackage

// File: rtl/sobel_kernel3x3.sv
// Three-stage Sobel kernel over one 3x3 window.
// Ports: clk, reset (async active-low); winL/winM/winR = left/centre/right
// columns, element 0 = top row; gx/gy signed gradients, mag = |gx|+|gy|,
// edgeFlag = mag >= THRESH. All outputs registered, 3 cycles of latency.
module sobel_kernel3x3
    import sobel_pkg::*;
#(
    parameter int THRESH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0][PIXW-1:0]     winL,
    input  logic [2:0][PIXW-1:0]     winM,
    input  logic [2:0][PIXW-1:0]     winR,
    output logic signed [GRADW-1:0]  gx,
    output logic signed [GRADW-1:0]  gy,
    output logic [MAGW-1:0]          mag,
    output logic                     edgeFlag
);

    logic [SUMW-1:0]          sumL_r, sumR_r;
    logic signed [DIFW-1:0]   diffL_r, diffM_r, diffR_r;
    logic signed [GRADW-1:0]  gx_r, gy_r;

    // S1: column sums for Gx, bottom-minus-top differences for Gy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sumL_r  <= '0;
            sumR_r  <= '0;
            diffL_r <= '0;
            diffM_r <= '0;
            diffR_r <= '0;
        end else begin
            sumL_r  <= weightedSum(winL[0], winL[1], winL[2]);
            sumR_r  <= weightedSum(winR[0], winR[1], winR[2]);
            diffL_r <= $signed({1'b0, winL[2]}) - $signed({1'b0, winL[0]});
            diffM_r <= $signed({1'b0, winM[2]}) - $signed({1'b0, winM[0]});
            diffR_r <= $signed({1'b0, winR[2]}) - $signed({1'b0, winR[0]});
        end
    end

    // S2: signed gradients.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gx_r <= '0;
            gy_r <= '0;
        end else begin
            gx_r <= $signed({1'b0, sumR_r}) - $signed({1'b0, sumL_r});
            gy_r <= weightedDiff(diffL_r, diffM_r, diffR_r);
        end
    end

    // S3: L1 magnitude, threshold flag and gradient output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gx       <= '0;
            gy       <= '0;
            mag      <= '0;
            edgeFlag <= 1'b0;
        end else begin
            gx       <= gx_r;
            gy       <= gy_r;
            mag      <= MAGW'(absVal(gx_r)) + MAGW'(absVal(gy_r));
            edgeFlag <= (MAGW'(absVal(gx_r)) + MAGW'(absVal(gy_r))) >= MAGW'(THRESH);
        end
    end

endmodule

// File: rtl/sobel_gradient_pair.sv
// Sobel gradient stage for two stacked centre rows (B and C).
// Ports: clk, reset (async active-low), frameStart, pixValid, rowA..rowD
// ([31:16] = column k, [15:0] = column k+1); outputs outValid, outCol,
// magB/magC, gxB/gyB/gxC/gyC, edgeB/edgeC, lineDone. Results appear three
// cycles after the beat; border columns 0 and LINEW-1 are suppressed.
module sobel_gradient_pair
    import sobel_pkg::*;
#(
    parameter int LINEW  = 2048,
    parameter int COLW   = 12,
    parameter int THRESH = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frameStart,
    input  logic                    pixValid,
    input  logic [31:0]             rowA,
    input  logic [31:0]             rowB,
    input  logic [31:0]             rowC,
    input  logic [31:0]             rowD,
    output logic                    outValid,
    output logic [COLW-1:0]         outCol,
    output logic [MAGW-1:0]         magB,
    output logic [MAGW-1:0]         magC,
    output logic signed [GRADW-1:0] gxB,
    output logic signed [GRADW-1:0] gyB,
    output logic signed [GRADW-1:0] gxC,
    output logic signed [GRADW-1:0] gyC,
    output logic                    edgeB,
    output logic                    edgeC,
    output logic                    lineDone
);

    localparam logic [COLW-1:0] LAST_COL = COLW'(LINEW - 1);
    localparam logic [COLW-1:0] LAST_OUT = COLW'(LINEW - 2);

    colWin_t               prevCol_r;
    logic [COLW-1:0]       colCnt_r;
    logic [COLW-1:0]       curCol_s, colNext_s;
    logic                  keep_s, last_s;
    logic [1:0]            vldPipe_r, ldPipe_r;
    logic [1:0][COLW-1:0]  colPipe_r;
    logic [2:0][PIXW-1:0]  winLB_s, winMB_s, winRB_s;
    logic [2:0][PIXW-1:0]  winLC_s, winMC_s, winRC_s;

    // Column index of the current beat and the counter's next value.
    always_comb begin
        curCol_s  = colCnt_r;
        colNext_s = colCnt_r;
        if (frameStart) begin
            curCol_s = '0;
        end else begin
            curCol_s = colCnt_r;
        end
        if (pixValid) begin
            colNext_s = (curCol_s == LAST_COL) ? '0 : curCol_s + COLW'(1);
        end else begin
            colNext_s = curCol_s;
        end
        keep_s = pixValid && (curCol_s >= COLW'(1)) && (curCol_s <= LAST_OUT);
        last_s = keep_s && (curCol_s == LAST_OUT);
    end

    // Window assembly: element 0 is the top row of each 3x3 neighbourhood.
    always_comb begin
        winLB_s = {prevCol_r.pixC, prevCol_r.pixB, prevCol_r.pixA};
        winMB_s = {rowC[31:16], rowB[31:16], rowA[31:16]};
        winRB_s = {rowC[15:0],  rowB[15:0],  rowA[15:0]};
        winLC_s = {prevCol_r.pixD, prevCol_r.pixC, prevCol_r.pixB};
        winMC_s = {rowD[31:16], rowC[31:16], rowB[31:16]};
        winRC_s = {rowD[15:0],  rowC[15:0],  rowB[15:0]};
    end

    // Previous-column capture and column counter; both hold through bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevCol_r <= '0;
            colCnt_r  <= '0;
        end else begin
            colCnt_r <= colNext_s;
            if (pixValid) begin
                prevCol_r <= '{pixA: rowA[31:16], pixB: rowB[31:16],
                               pixC: rowC[31:16], pixD: rowD[31:16]};
            end else begin
                prevCol_r <= prevCol_r;
            end
        end
    end

    // Valid/column/lineDone delay line aligned with the kernel's three stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vldPipe_r <= '0;
            ldPipe_r  <= '0;
            colPipe_r <= '0;
            outValid  <= 1'b0;
            lineDone  <= 1'b0;
            outCol    <= '0;
        end else begin
            vldPipe_r <= {vldPipe_r[0], keep_s};
            ldPipe_r  <= {ldPipe_r[0], last_s};
            colPipe_r <= {colPipe_r[0], curCol_s};
            outValid  <= vldPipe_r[1];
            lineDone  <= ldPipe_r[1];
            outCol    <= colPipe_r[1];
        end
    end

    sobel_kernel3x3 #(.THRESH(THRESH)) kernelB (
        .clk(clk), .reset(reset),
        .winL(winLB_s), .winM(winMB_s), .winR(winRB_s),
        .gx(gxB), .gy(gyB), .mag(magB), .edgeFlag(edgeB)
    );

    sobel_kernel3x3 #(.THRESH(THRESH)) kernelC (
        .clk(clk), .reset(reset),
        .winL(winLC_s), .winM(winMC_s), .winR(winRC_s),
        .gx(gxC), .gy(gyC), .mag(magC), .edgeFlag(edgeC)
    );

endmodule

// File: tb/tb_sobel_gradient_pair.sv
// Self-checking bench for sobel_gradient_pair with LINEW=8: directed
// patterns, bubbles, mid-line reset and random beats against a plain
// arithmetic reference of the Sobel operator.
module tb_sobel_gradient_pair;

    localparam int LINEW  = 8;
    localparam int COLW   = 4;
    localparam int THRESH = 1024;

    logic               clk, reset, frameStart, pixValid;
    logic [31:0]        rowA, rowB, rowC, rowD;
    logic               outValid, lineDone, edgeB, edgeC;
    logic [COLW-1:0]    outCol;
    logic [19:0]        magB, magC;
    logic signed [18:0] gxB, gyB, gxC, gyC;

    sobel_gradient_pair #(.LINEW(LINEW), .COLW(COLW), .THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .pixValid(pixValid),
        .rowA(rowA), .rowB(rowB), .rowC(rowC), .rowD(rowD),
        .outValid(outValid), .outCol(outCol), .magB(magB), .magC(magC),
        .gxB(gxB), .gyB(gyB), .gxC(gxC), .gyC(gyC),
        .edgeB(edgeB), .edgeC(edgeC), .lineDone(lineDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        bit v;
        int col;
        bit ld;
        int gx[2];
        int gy[2];
        int mag[2];
        bit e[2];
    } exp_t;

    exp_t blankExp;
    exp_t q[$];
    int   prevPix[4];
    int   colM;

    task automatic checkVal(input string tag, input int obs, input int expv);
        testsRun++;
        if (obs != expv) begin
            testsFailed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int hi, input int lo);
        logic [31:0] w;
        w = {hi[15:0], lo[15:0]};
        return w;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: Sobel on the 3x3 neighbourhoods around rows B and C.
    function automatic exp_t model(input bit v, input bit fs, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] c,
                                   input logic [31:0] d);
        exp_t e;
        logic [31:0] r[4];
        int L[4], M[4], R[4];
        int col;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        for (int i = 0; i < 4; i++) begin
            L[i] = prevPix[i];
            M[i] = int'(r[i][31:16]);
            R[i] = int'(r[i][15:0]);
        end
        col   = fs ? 0 : colM;
        e.v   = v && (col >= 1) && (col <= LINEW - 2);
        e.col = col;
        e.ld  = e.v && (col == LINEW - 2);
        for (int k = 0; k < 2; k++) begin
            e.gx[k]  = (R[k] + 2*R[k+1] + R[k+2]) - (L[k] + 2*L[k+1] + L[k+2]);
            e.gy[k]  = (L[k+2] + 2*M[k+2] + R[k+2]) - (L[k] + 2*M[k] + R[k]);
            e.mag[k] = iabs(e.gx[k]) + iabs(e.gy[k]);
            e.e[k]   = (e.mag[k] >= THRESH);
        end
        if (v) begin
            for (int i = 0; i < 4; i++) prevPix[i] = M[i];
            colM = (col + 1) % LINEW;
        end else begin
            colM = col;
        end
        return e;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) prevPix[i] = 0;
        colM = 0;
        q.delete();
        q.push_back(blankExp);
        q.push_back(blankExp);
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, ".outValid"}, int'(outValid), 0);
        checkVal({tag, ".lineDone"}, int'(lineDone), 0);
        checkVal({tag, ".outCol"},   int'(outCol), 0);
        checkVal({tag, ".magB"},     int'(magB), 0);
        checkVal({tag, ".magC"},     int'(magC), 0);
        checkVal({tag, ".gxB"},      int'(gxB), 0);
        checkVal({tag, ".gyC"},      int'(gyC), 0);
        checkVal({tag, ".edgeB"},    int'(edgeB), 0);
        checkVal({tag, ".edgeC"},    int'(edgeC), 0);
    endtask

    // One clock: drive a beat, then check the beat issued two steps earlier,
    // which has now passed through all three register stages.
    task automatic step(input bit v, input bit fs, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        pixValid = v; frameStart = fs;
        rowA = a; rowB = b; rowC = c; rowD = d;
        q.push_back(model(v, fs, a, b, c, d));
        @(posedge clk);
        #1;
        e = q.pop_front();
        checkVal("outValid", int'(outValid), int'(e.v));
        checkVal("lineDone", int'(lineDone), int'(e.ld));
        if (e.v) begin
            checkVal("outCol", int'(outCol), e.col);
            checkVal("gxB",    int'(gxB), e.gx[0]);
            checkVal("gyB",    int'(gyB), e.gy[0]);
            checkVal("magB",   int'(magB), e.mag[0]);
            checkVal("edgeB",  int'(edgeB), int'(e.e[0]));
            checkVal("gxC",    int'(gxC), e.gx[1]);
            checkVal("gyC",    int'(gyC), e.gy[1]);
            checkVal("magC",   int'(magC), e.mag[1]);
            checkVal("edgeC",  int'(edgeC), int'(e.e[1]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic uni(input bit fs, input int hi, input int lo);
        step(1'b1, fs, pk(hi, lo), pk(hi, lo), pk(hi, lo), pk(hi, lo));
    endtask

    // Directed patterns; gap > 0 inserts 1..gap idle cycles after each beat.
    task automatic directed(input int gap);
        for (int i = 0; i < LINEW; i++) begin
            uni(i == 0, 100, 100);
            if (gap > 0) idle($urandom_range(1, gap));
        end
        uni(1'b1, 0, 0);
        uni(1'b0, 1000, 1000);
        if (gap > 0) idle($urandom_range(1, gap));
        step(1'b1, 1'b1, pk(0, 0), pk(500, 500), pk(500, 500), pk(500, 500));
        step(1'b1, 1'b0, pk(0, 0), pk(500, 500), pk(500, 500), pk(500, 500));
        if (gap > 0) idle($urandom_range(1, gap));
        uni(1'b1, 0, 0);
        uni(1'b0, 65535, 65535);
        if (gap > 0) idle($urandom_range(1, gap));
        uni(1'b1, 65535, 65535);
        uni(1'b0, 0, 0);
        if (gap > 0) idle($urandom_range(1, gap));
        uni(1'b1, 0, 0);
        step(1'b1, 1'b0, pk(0, 0), pk(65535, 65535), pk(65535, 65535), pk(65535, 65535));
        idle(3);
    endtask

    initial begin
        reset = 1'b0; frameStart = 1'b0; pixValid = 1'b0;
        rowA = 32'd0; rowB = 32'd0; rowC = 32'd0; rowD = 32'd0;
        #3;
        checkZero("reset");
        @(negedge clk);
        reset = 1'b1;
        modelReset();

        directed(0);
        directed(3);

        // Mid-line reset with results for columns 3 and 4 still in flight.
        for (int i = 0; i < 5; i++) uni(i == 0, 200 + 37*i, 300 + 11*i);
        pixValid = 1'b0; frameStart = 1'b0;
        #1 reset = 1'b0;
        #1 checkZero("midReset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        for (int i = 0; i < 4; i++) uni(1'b0, 40*i, 4000 - 40*i);
        idle(3);

        // Random beats, bubbles and occasional frame restarts.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                 $urandom, $urandom, $urandom, $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
